alu_req_arbiter: RTL
====================

// Module: alu_req_arbiter
//
// PURPOSE
// - Shares the single ALU between two requesters (0: execute-stage issue, 1: multi-cycle helper such as a
//   mem-address/LLB-LHB sequencer). Accepts one operation at a time, drives the ALU operand/opcode inputs for
//   exactly one cycle, and returns the result on a valid/ready channel tagged with the requester id.
// - Gates ALU flag updates: flags (V,N,Z) may only change on the clock edge that ends an EXEC cycle.
//
// PARAMETERS
// - DATA_W   16     operand/result width; must match the ALU.
// - IDLE_OP  4'hC   opcode driven to the ALU outside EXEC; must be a non-flag-setting opcode (B).
//
// PORTS
// - clk        in   1       single clock; all state updates on rising edge.
// - rst        in   1       synchronous, active-high reset.
// - req_valid  in   2       per-requester request valid (bit i = requester i).
// - req_ready  out  2       per-requester accept; handshake completes when req_valid[i] & req_ready[i].
// - req0_op    in   4       requester 0 opcode.   req1_op  in  4  requester 1 opcode.
// - req0_a/b   in   DATA_W  requester 0 operands. req1_a/b in DATA_W requester 1 operands.
// - alu_in1    out  DATA_W  ALU operand 1 (from operand register).
// - alu_in2    out  DATA_W  ALU operand 2 (from operand register).
// - alu_op     out  4       ALU opcode; IDLE_OP except in EXEC.
// - alu_out    in   DATA_W  ALU combinational result.
// - alu_flags  in   3       ALU flag register output {V,N,Z}.
// - res_valid  out  1       result valid.   res_ready in 1 consumer accept.
// - res_data   out  DATA_W  registered result.  res_id out 1 requester that issued it.
// - res_flags  out  3       alu_flags as seen in RESP (post-update).
//
// BEHAVIOUR
// - FSM states: IDLE, EXEC, RESP. Reset: state=IDLE, rr_ptr=0, res_valid=0, res_data=0, res_id=0,
//   operand regs=0, alu_op=IDLE_OP, req_ready=2'b00.
// - IDLE: req_ready = one-hot grant from round-robin (priority to rr_ptr; other requester if rr_ptr idle);
//   req_ready=0 for non-requesting bits (no speculative ready). On handshake: latch op/a/b into operand regs,
//   latch id, rr_ptr <= ~id, -> EXEC. No request: stay IDLE.
// - EXEC (exactly 1 cycle): alu_op=latched op, alu_in1/2=operand regs; req_ready=0. At edge: res_data<=alu_out,
//   res_id<=id, res_valid<=1, -> RESP. ALU flags update on this same edge per op.
// - RESP: res_valid=1, data/id stable until res_ready. On res_valid&res_ready: res_valid<=0; if a request is
//   pending, grant it in the same cycle (req_ready asserted in RESP when res_ready=1) and go directly to EXEC;
//   else -> IDLE. req_ready is combinationally dependent on res_ready in RESP only.
// - Latency: handshake at cycle N -> res_valid at N+2. Max throughput 1 op / 2 cycles with res_ready held high.
// - Backpressure: res_ready low holds RESP indefinitely; no further grants; alu_op stays IDLE_OP (flags frozen).
// - Simultaneous requests: alternate strictly; a requester holding valid is never starved > 1 op.
// - Opcodes 4'hC-4'hF are passed through unchanged (result whatever the ALU returns, typically 0).
// - Request inputs are sampled only on handshake; changes outside handshake have no effect.
// - Reset mid-EXEC or mid-RESP: pending op/result dropped, all outputs to reset values next cycle.
//
// STRUCTURE
// - Shared package: state enum {IDLE,EXEC,RESP}, opcode constants (ADD=0..HLT=F), IDLE_OP default.
// - Optional sub-module rr_arb2 (2-way round-robin grant, pointer update on accept); rest is flat.
// - ALU is instantiated by the parent, not inside this block.
//
// TESTING (bench instantiates ALU + this block)
// - Single op: req0 ADD a=16'h0003 b=16'h0004 -> res_valid 2 cycles later, res_data=16'h0007, res_id=0, Z=0.
// - Both request every cycle, res_ready=1: ids alternate 0,1,0,1; one result every 2 cycles.
// - SUB 16'h8000-16'h0001 -> res_data=16'h7FFF, res_flags V=1,N=0; follow with SLL of 0 -> Z=1, V/N unchanged.
// - Flag freeze: XOR result 0 (Z=1), then hold res_ready=0 for 10 cycles -> alu_op==IDLE_OP, flags unchanged.
// - Backpressure: res_ready=0 with req1 pending -> req_ready=0 throughout; release -> req1 granted same cycle.
// - rst asserted in EXEC -> next cycle res_valid=0, state IDLE, grant priority back to requester 0.

Source files
------------

// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, EXEC, RESP)
//   - OP_*        : ALU opcode encodings
//   - IDLE_OP_DEFAULT : opcode driven to the ALU whenever no operation is
//                       executing; it must not update the flag register.
package alu_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_RED    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRA    = 4'h6;
  localparam logic [3:0] OP_ROR    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // Branch opcode never touches V/N/Z, so it is safe to park the ALU on it.
  localparam logic [3:0] IDLE_OP_DEFAULT = OP_B;

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant generator.
//   clk, rst  : clock, synchronous active-high reset (pointer -> requester 0)
//   req[1:0]  : request vector
//   en        : grants are only issued while en is high
//   grant[1:0]: one-hot grant, never set for a non-requesting bit
//   grant_id  : index of the requester that would be granted
// The pointer moves past the granted requester whenever a grant is issued;
// a grant is always taken in the same cycle because it is only driven to
// requesters that are already asserting valid.
module alu_req_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr_reg;
  logic ptr_next;
  logic accept;

  // Pointer holder wins if requesting, otherwise the other requester.
  assign grant_id = req[ptr_reg] ? ptr_reg : ~ptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = en & req[gi] & (grant_id == 1'(gi));
    end
  endgenerate

  assign accept   = |grant;
  assign ptr_next = accept ? ~grant_id : ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters (0: execute-stage issue,
// 1: multi-cycle helper). One operation is in flight at a time: it is
// latched on the request handshake, presented to the ALU for exactly one
// EXEC cycle, and the registered result is offered on a valid/ready port
// tagged with the issuing requester.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready[1:0]  : per-requester request handshake
//   req0_op/a/b, req1_op/a/b  : per-requester opcode and operands
//   alu_in1/alu_in2/alu_op    : ALU drive (alu_op = IDLE_OP outside EXEC)
//   alu_out, alu_flags        : ALU combinational result and flag register
//   res_valid/res_ready       : result handshake
//   res_data/res_id/res_flags : result, requester tag, post-update flags
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int         DATA_W  = 16,
  parameter logic [3:0] IDLE_OP = IDLE_OP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_flags,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  output logic [2:0]        res_flags
);

  arb_state_t        state_reg;
  arb_state_t        state_next;

  logic [3:0]        op_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              id_reg;
  logic [DATA_W-1:0] res_data_reg;
  logic              res_id_reg;
  logic              res_valid_reg;

  logic              grant_en;
  logic              grant_id;
  logic [1:0]        grant;
  logic              accept;

  // Round-robin grant; the enable is masked by rst so no handshake can be
  // seen by a requester while the block is being reset.
  alu_req_arbiter_rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .en       (grant_en & ~rst),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & req_ready);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        // A request accepted in the same cycle as the result goes straight
        // to EXEC, giving back-to-back ops every two cycles.
        if (res_ready) state_next = accept ? EXEC : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: grants are only offered when the result slot is free
  // (IDLE) or being freed this cycle (RESP with res_ready); the ALU sees
  // the real opcode in EXEC only, which keeps the flag register frozen
  // at all other times.
  always_comb begin
    grant_en = 1'b0;
    alu_op   = IDLE_OP;
    case (state_reg)
      IDLE:    grant_en = 1'b1;
      EXEC:    alu_op   = op_reg;
      RESP:    grant_en = res_ready;
      default: grant_en = 1'b0;
    endcase
  end

  // Operand capture and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg        <= IDLE_OP;
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= 1'b0;
      res_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        op_reg <= grant_id ? req1_op : req0_op;
        a_reg  <= grant_id ? req1_a  : req0_a;
        b_reg  <= grant_id ? req1_b  : req0_b;
        id_reg <= grant_id;
      end
      if (state_reg == EXEC) begin
        res_data_reg  <= alu_out;
        res_id_reg    <= id_reg;
        res_valid_reg <= 1'b1;
      end else if ((state_reg == RESP) && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign alu_in1   = a_reg;
  assign alu_in2   = b_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  // Flags only move on the EXEC edge, so in RESP they already hold the
  // values produced by this result.
  assign res_flags = alu_flags;

endmodule
